axi_mem_slave: RTL and testbench

AXI4 memory-mapped slave with an internal word-addressed RAM, attached directly downstream of the axi_master VIP in AXI simulation benches. It replaces hand-driven awready/wready/bvalid/rvalid stimulus with a protocol-correct responder that stores write bursts and returns them on read bursts. Read and write channels are served by independent state machines.

---
 rtl/axi_mem_slave.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_mem_slave
//
// AXI4 memory-mapped slave backed by a word-addressed 32-bit RAM of
// 2^ADDR_W words. Read and write channels run independent state machines,
// each with at most one burst in flight. Bursts with an illegal address,
// size, burst type or wlast placement are still run for the full len+1
// beats but answer SLVERR.
//
// Optional feature macro: AXI_MEM_SLAVE_WRAP_EN
//   defined     : WRAP bursts with len 1/3/7/15 wrap at a (len+1)*4-byte
//                 boundary; any other WRAP len is SLVERR, addressed as INCR.
//   not defined : every WRAP burst is SLVERR, addressed as INCR.
//
// Parameters
//   ADDR_W     RAM word-address bits
//   BASE_ADDR  byte base address, aligned to 2^(ADDR_W+2)
//
// Ports
//   aclk, aresetn                 clock (rising edge), async active-low reset
//   s_axi_aw*  (addr/len/size/burst/valid/ready)   write address channel
//   s_axi_w*   (data/strb/last/valid/ready)        write data channel
//   s_axi_b*   (resp/valid/ready)                  write response channel
//   s_axi_ar*  (addr/len/size/burst/valid/ready)   read address channel
//   s_axi_r*   (data/resp/last/valid/ready)        read data channel
// -----------------------------------------------------------------------------
module axi_mem_slave #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    logic [31:0] mem_r [DEPTH];

`ifdef AXI_MEM_SLAVE_WRAP_EN
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
`endif

    // A non-zero mask marks a wrapping burst: the masked low index bits
    // count, the upper bits stay pinned to the wrap boundary.
    function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx,
                                                   input logic [1:0]        burst,
                                                   input logic [3:0]        mask);
        logic [ADDR_W-1:0] inc_v;
        logic [ADDR_W-1:0] mask_v;
        inc_v  = idx + {{(ADDR_W-1){1'b0}}, 1'b1};
        mask_v = ADDR_W'(mask);
        if (burst == BURST_FIXED) begin
            next_idx = idx;
        end else if (mask != 4'h0) begin
            next_idx = (idx & ~mask_v) | (inc_v & mask_v);
        end else begin
            next_idx = inc_v;
        end
    endfunction

    // write-side state
    logic [1:0]        w_state_r;
    logic [ADDR_W-1:0] w_idx_r;
    logic [7:0]        w_len_r;
    logic [1:0]        w_burst_r;
    logic [3:0]        w_mask_r;
    logic [7:0]        w_cnt_r;
    logic              w_err_r;
    logic              w_oor_r;

    // read-side state
    logic              r_state_r;
    logic [ADDR_W-1:0] r_idx_r;
    logic [7:0]        r_len_r;
    logic [1:0]        r_burst_r;
    logic [3:0]        r_mask_r;
    logic [7:0]        r_cnt_r;
    logic              r_oor_r;

    logic              aw_err_s;
    logic [3:0]        aw_mask_s;
    logic              aw_oor_s;
    logic              ar_err_s;
    logic [3:0]        ar_mask_s;
    logic              ar_oor_s;
    logic              w_beat_s;
    logic              w_last_err_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] w_next_s;
    logic [ADDR_W-1:0] r_next_s;
    logic [ADDR_W-1:0] ar_idx_s;

    // byte-offset bits never select anything in a word-wide RAM
    logic unused_s;
    assign unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Classify the write address request (size/burst legality, wrap mask)
    always_comb begin
        aw_oor_s  = (s_axi_awaddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
        aw_err_s  = (s_axi_awsize != 3'b010) || (s_axi_awburst == BURST_RSVD);
        aw_mask_s = 4'h0;
`ifdef AXI_MEM_SLAVE_WRAP_EN
        if (s_axi_awburst == BURST_WRAP) begin
            if (wrap_len_ok(s_axi_awlen)) begin
                aw_mask_s = s_axi_awlen[3:0];
            end else begin
                aw_err_s = 1'b1;
            end
        end else begin
            aw_mask_s = 4'h0;
        end
`else
        if (s_axi_awburst == BURST_WRAP) begin
            aw_err_s = 1'b1;
        end else begin
            aw_mask_s = 4'h0;
        end
`endif
    end

    // Classify the read address request (size/burst legality, wrap mask)
    always_comb begin
        ar_oor_s  = (s_axi_araddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
        ar_err_s  = (s_axi_arsize != 3'b010) || (s_axi_arburst == BURST_RSVD);
        ar_mask_s = 4'h0;
        ar_idx_s  = s_axi_araddr[ADDR_W+1:2];
`ifdef AXI_MEM_SLAVE_WRAP_EN
        if (s_axi_arburst == BURST_WRAP) begin
            if (wrap_len_ok(s_axi_arlen)) begin
                ar_mask_s = s_axi_arlen[3:0];
            end else begin
                ar_err_s = 1'b1;
            end
        end else begin
            ar_mask_s = 4'h0;
        end
`else
        if (s_axi_arburst == BURST_WRAP) begin
            ar_err_s = 1'b1;
        end else begin
            ar_mask_s = 4'h0;
        end
`endif
    end

    // Per-beat write qualifiers and next addresses of both channels
    always_comb begin
        w_beat_s     = s_axi_wvalid && s_axi_wready;
        w_last_err_s = (s_axi_wlast != (w_cnt_r == w_len_r));
        mem_we_s     = w_beat_s && !w_oor_r;
        w_next_s     = next_idx(w_idx_r, w_burst_r, w_mask_r);
        r_next_s     = next_idx(r_idx_r, r_burst_r, r_mask_r);
    end

    // RAM byte-lane writes; kept out of reset so contents survive it
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_r[w_idx_r][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Write FSM: accept address, take len+1 beats, return one response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_r     <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            w_idx_r       <= {ADDR_W{1'b0}};
            w_len_r       <= 8'd0;
            w_burst_r     <= 2'b00;
            w_mask_r      <= 4'h0;
            w_cnt_r       <= 8'd0;
            w_err_r       <= 1'b0;
            w_oor_r       <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_idx_r       <= s_axi_awaddr[ADDR_W+1:2];
                        w_len_r       <= s_axi_awlen;
                        w_burst_r     <= s_axi_awburst;
                        w_mask_r      <= aw_mask_s;
                        w_cnt_r       <= 8'd0;
                        w_err_r       <= aw_err_s || aw_oor_s;
                        w_oor_r       <= aw_oor_s;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state_r     <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    // termination is by beat count; a misplaced wlast only flags the error
                    if (w_beat_s) begin
                        if (w_cnt_r == w_len_r) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (w_err_r || w_last_err_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_r    <= W_RESP;
                        end else begin
                            w_cnt_r <= w_cnt_r + 8'd1;
                            w_idx_r <= w_next_s;
                            w_err_r <= w_err_r || w_last_err_s;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state_r     <= W_IDLE;
                    end
                end
                default: begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    w_state_r     <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: accept address, stream len+1 registered beats
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_r     <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= 32'h0000_0000;
            r_idx_r       <= {ADDR_W{1'b0}};
            r_len_r       <= 8'd0;
            r_burst_r     <= 2'b00;
            r_mask_r      <= 4'h0;
            r_cnt_r       <= 8'd0;
            r_oor_r       <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_idx_r       <= ar_idx_s;
                        r_len_r       <= s_axi_arlen;
                        r_burst_r     <= s_axi_arburst;
                        r_mask_r      <= ar_mask_s;
                        r_cnt_r       <= 8'd0;
                        r_oor_r       <= ar_oor_s;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rresp   <= (ar_err_s || ar_oor_s) ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rdata   <= ar_oor_s ? 32'h0000_0000 : mem_r[ar_idx_s];
                        s_axi_arready <= 1'b0;
                        r_state_r     <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    // RAM is sampled at the edge, so a same-cycle write is not seen
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state_r     <= R_IDLE;
                        end else begin
                            r_idx_r     <= r_next_s;
                            r_cnt_r     <= r_cnt_r + 8'd1;
                            s_axi_rlast <= ((r_cnt_r + 8'd1) == r_len_r);
                            s_axi_rdata <= r_oor_r ? 32'h0000_0000 : mem_r[r_next_s];
                        end
                    end
                end
                default: begin
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b0;
                    s_axi_rlast   <= 1'b0;
                    r_state_r     <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_slave
//
// Self-checking bench for axi_mem_slave (ADDR_W=10, BASE_ADDR=0). A byte-level
// reference RAM plus arithmetic address/response rules predict every bresp,
// rdata, rresp and rlast. Honours AXI_MEM_SLAVE_WRAP_EN when defined.
// -----------------------------------------------------------------------------
module tb_axi_mem_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] s_axi_awaddr = 32'h0;
    logic [7:0]  s_axi_awlen = 8'h0;
    logic [2:0]  s_axi_awsize = 3'h2;
    logic [1:0]  s_axi_awburst = 2'h1;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = 32'h0;
    logic [3:0]  s_axi_wstrb = 4'h0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = 32'h0;
    logic [7:0]  s_axi_arlen = 8'h0;
    logic [2:0]  s_axi_arsize = 3'h2;
    logic [1:0]  s_axi_arburst = 2'h1;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] ref_mem [0:1023];
    logic [31:0] wd [0:255];
    logic [3:0]  ws [0:255];
    logic [31:0] rd_data [0:255];
    logic [1:0]  rd_resp [0:255];
    logic        rd_last [0:255];

    axi_mem_slave #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 aclk = ~aclk;

    // ---------------- reference model ----------------
    function automatic bit wrap_ok(int len);
`ifdef AXI_MEM_SLAVE_WRAP_EN
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int beat_word(logic [31:0] addr, int len, logic [1:0] burst, int i);
        int w0, n, lo;
        w0 = int'(addr[11:2]);
        if (burst == 2'b00) return w0;
        if (burst == 2'b10 && wrap_ok(len)) begin
            n  = len + 1;
            lo = (w0 / n) * n;
            return lo + ((w0 - lo + i) % n);
        end
        return (w0 + i) % 1024;
    endfunction

    function automatic bit exp_err(logic [31:0] addr, int len, logic [2:0] size, logic [1:0] burst);
        return (addr[31:12] != 20'h0) || (size != 3'b010) || (burst == 2'b11) ||
               (burst == 2'b10 && !wrap_ok(len));
    endfunction

    function automatic logic [31:0] exp_rdata(logic [31:0] addr, int len, logic [1:0] burst, int i);
        if (addr[31:12] != 20'h0) return 32'h0;
        return ref_mem[beat_word(addr, len, burst, i)];
    endfunction

    task automatic model_write(logic [31:0] addr, int len, logic [1:0] burst);
        int w;
        if (addr[31:12] == 20'h0) begin
            for (int i = 0; i <= len; i++) begin
                w = beat_word(addr, len, burst, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
    endtask

    // ---------------- bus drivers ----------------
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input int last_at, input bit gaps,
                             output logic [1:0] resp, output logic first_wready, output logic prompt_b);
        int t;
        s_axi_awaddr = addr; s_axi_awlen = len[7:0]; s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 200) begin @(posedge aclk); #1; t++; end
        if (!s_axi_awready) begin total++; bad++; $display("FAIL aw_handshake: awready=%b want 1", s_axi_awready); end
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        first_wready = s_axi_wready;
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_axi_wvalid = 1'b0; @(posedge aclk); #1;
            end
            s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = (i == last_at);
            t = 0;
            while (!s_axi_wready && t < 200) begin @(posedge aclk); #1; t++; end
            if (!s_axi_wready) begin total++; bad++; $display("FAIL w_beat %0d: wready=%b want 1", i, s_axi_wready); end
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        prompt_b = s_axi_bvalid;
        t = 0;
        while (!s_axi_bvalid && t < 200) begin @(posedge aclk); #1; t++; end
        if (!s_axi_bvalid) begin total++; bad++; $display("FAIL b_wait: bvalid=%b want 1", s_axi_bvalid); end
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input bit stall, output logic first_rvalid);
        int t, i, cyc;
        bit held;
        logic [34:0] hv;
        s_axi_araddr = addr; s_axi_arlen = len[7:0]; s_axi_arsize = size; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 200) begin @(posedge aclk); #1; t++; end
        if (!s_axi_arready) begin total++; bad++; $display("FAIL ar_handshake: arready=%b want 1", s_axi_arready); end
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        first_rvalid = s_axi_rvalid;
        i = 0; cyc = 0; held = 1'b0; hv = 35'h0;
        while (i <= len && cyc < 4000) begin
            if (s_axi_rvalid) begin
                if (held) begin
                    total++;
                    if ({s_axi_rdata, s_axi_rresp, s_axi_rlast} !== hv) begin
                        bad++;
                        $display("FAIL r_stall_stable beat %0d: got %h want %h", i,
                                 {s_axi_rdata, s_axi_rresp, s_axi_rlast}, hv);
                    end
                end
                s_axi_rready = stall ? cyc[0] : 1'b1;
                if (s_axi_rready) begin
                    rd_data[i] = s_axi_rdata; rd_resp[i] = s_axi_rresp; rd_last[i] = s_axi_rlast;
                    i++; held = 1'b0;
                end else begin
                    hv = {s_axi_rdata, s_axi_rresp, s_axi_rlast}; held = 1'b1;
                end
            end else begin
                s_axi_rready = 1'b0;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_axi_rready = 1'b0;
        if (i <= len) begin total++; bad++; $display("FAIL r_timeout: beats=%0d want %0d", i, len + 1); end
    endtask

    // compares a whole read burst against the model
    task automatic check_read(input string nm, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic [1:0] er;
        er = exp_err(addr, len, size, burst) ? 2'b10 : 2'b00;
        for (int i = 0; i <= len; i++) begin
            total++;
            if (rd_data[i] !== exp_rdata(addr, len, burst, i) || rd_resp[i] !== er || rd_last[i] !== (i == len)) begin
                bad++;
                $display("FAIL %s beat %0d: got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                         nm, i, rd_data[i], rd_resp[i], rd_last[i], exp_rdata(addr, len, burst, i), er, (i == len));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid,
             s_axi_rlast, s_axi_rresp, s_axi_rdata} !== 42'h0) begin
            bad++;
            $display("FAIL reset_values: aw=%b w=%b b=%b br=%b ar=%b rv=%b rl=%b rr=%b rd=%h want all 0",
                     s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                     s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        total++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            bad++; $display("FAIL ready_after_reset: aw/ar=%b want 11", {s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_fill();
        logic [1:0] r; logic fw, pb;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            axi_write(32'(k * 1024), 255, 3'b010, 2'b01, 255, 1'b0, r, fw, pb);
            model_write(32'(k * 1024), 255, 2'b01);
            total++;
            if (r !== 2'b00) begin bad++; $display("FAIL fill_bresp %0d: got %b want 00", k, r); end
        end
    endtask

    task automatic test_single();
        logic [1:0] r; logic fw, pb, fr;
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(32'h10, 0, 3'b010, 2'b01, 0, 1'b0, r, fw, pb);
        model_write(32'h10, 0, 2'b01);
        total++;
        if (r !== 2'b00 || fw !== 1'b1 || pb !== 1'b1) begin
            bad++; $display("FAIL single_write: bresp=%b wready@N+1=%b bvalid@M+1=%b want 00 1 1", r, fw, pb);
        end
        axi_read(32'h10, 0, 3'b010, 2'b01, 1'b0, fr);
        total++;
        if (fr !== 1'b1 || rd_data[0] !== 32'hDEAD_BEEF || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
            bad++; $display("FAIL single_read: rvalid@N+1=%b data=%h last=%b resp=%b want 1 deadbeef 1 00",
                            fr, rd_data[0], rd_last[0], rd_resp[0]);
        end
    endtask

    task automatic test_incr_stall();
        logic [1:0] r; logic fw, pb, fr;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(32'h100, 3, 3'b010, 2'b01, 3, 1'b1, r, fw, pb);
        model_write(32'h100, 3, 2'b01);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL incr_bresp: got %b want 00", r); end
        axi_read(32'h100, 3, 3'b010, 2'b01, 1'b1, fr);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                bad++; $display("FAIL incr_read beat %0d: data=%h last=%b want %h %b", i, rd_data[i], rd_last[i], 32'(i + 1), (i == 3));
            end
        end
    endtask

    task automatic test_partial();
        logic [1:0] r; logic fw, pb, fr;
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        axi_write(32'h20, 0, 3'b010, 2'b01, 0, 1'b0, r, fw, pb);
        model_write(32'h20, 0, 2'b01);
        wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
        axi_write(32'h20, 0, 3'b010, 2'b01, 0, 1'b0, r, fw, pb);
        model_write(32'h20, 0, 2'b01);
        axi_read(32'h20, 0, 3'b010, 2'b01, 1'b0, fr);
        total++;
        if (rd_data[0] !== 32'hFF22_FF44) begin bad++; $display("FAIL partial_strb: got %h want ff22ff44", rd_data[0]); end
    endtask

    task automatic test_wrap();
        logic [1:0] r; logic fw, pb, fr;
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        axi_write(32'h38, 3, 3'b010, 2'b10, 3, 1'b0, r, fw, pb);
        model_write(32'h38, 3, 2'b10);
        total++;
`ifdef AXI_MEM_SLAVE_WRAP_EN
        if (r !== 2'b00) begin bad++; $display("FAIL wrap_bresp: got %b want 00", r); end
`else
        if (r !== 2'b10) begin bad++; $display("FAIL wrap_bresp: got %b want 10", r); end
`endif
        axi_read(32'h30, 7, 3'b010, 2'b01, 1'b0, fr);
        check_read("wrap_readback", 32'h30, 7, 3'b010, 2'b01);
`ifdef AXI_MEM_SLAVE_WRAP_EN
        total++;
        if (rd_data[0] !== 32'hC || rd_data[1] !== 32'hD || rd_data[2] !== 32'hA || rd_data[3] !== 32'hB) begin
            bad++; $display("FAIL wrap_layout: got %h %h %h %h want c d a b", rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
`endif
        axi_read(32'h38, 2, 3'b010, 2'b10, 1'b0, fr);
        check_read("wrap_badlen", 32'h38, 2, 3'b010, 2'b10);
    endtask

    task automatic test_errors();
        logic [1:0] r; logic fw, pb, fr;
        axi_read(32'h1000, 1, 3'b010, 2'b01, 1'b0, fr);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10) begin
                bad++; $display("FAIL oor_read beat %0d: data=%h resp=%b want 0 10", i, rd_data[i], rd_resp[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(32'h80, 2, 3'b010, 2'b01, 1, 1'b0, r, fw, pb);
        model_write(32'h80, 2, 2'b01);
        total++;
        if (r !== 2'b10) begin bad++; $display("FAIL early_wlast_bresp: got %b want 10", r); end
        wd[0] = 32'h5555_AAAA; ws[0] = 4'hF;
        axi_write(32'h1010, 0, 3'b010, 2'b01, 0, 1'b0, r, fw, pb);
        total++;
        if (r !== 2'b10) begin bad++; $display("FAIL oor_write_bresp: got %b want 10", r); end
        axi_read(32'h10, 0, 3'b010, 2'b01, 1'b0, fr);
        check_read("oor_write_dropped", 32'h10, 0, 3'b010, 2'b01);
        axi_read(32'h80, 2, 3'b011, 2'b01, 1'b0, fr);
        check_read("size_err_read", 32'h80, 2, 3'b011, 2'b01);
    endtask

    task automatic test_reset_midburst();
        int t; logic fr;
        s_axi_araddr = 32'h0; s_axi_arlen = 8'd7; s_axi_arsize = 3'b010; s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 200) begin @(posedge aclk); #1; t++; end
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        total++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
            bad++; $display("FAIL async_reset: rvalid=%b arready=%b want 0 0", s_axi_rvalid, s_axi_arready);
        end
        s_axi_rready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        total++;
        if (s_axi_arready !== 1'b1) begin bad++; $display("FAIL arready_after_release: got %b want 1", s_axi_arready); end
        axi_read(32'h40, 3, 3'b010, 2'b01, 1'b0, fr);
        check_read("read_after_reset", 32'h40, 3, 3'b010, 2'b01);
    endtask

    task automatic test_back_to_back();
        logic [1:0] r; logic fw, pb, fr;
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            axi_write(32'h200, 3, 3'b010, 2'b01, 3, 1'b0, r, fw, pb);
            axi_read(32'h300, 3, 3'b010, 2'b01, 1'b0, fr);
        join
        check_read("concurrent_read", 32'h300, 3, 3'b010, 2'b01);
        model_write(32'h200, 3, 2'b01);
        axi_read(32'h200, 3, 3'b010, 2'b01, 1'b1, fr);
        check_read("concurrent_write", 32'h200, 3, 3'b010, 2'b01);
    endtask

    task automatic test_random();
        logic [1:0] r, burst; logic fw, pb, fr;
        logic [31:0] addr; logic [2:0] size; int len;
        for (int n = 0; n < 24; n++) begin
            len   = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 3));
            size  = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
            addr  = {20'h0, 10'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) addr[31:12] = 20'($urandom_range(1, 255));
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            axi_write(addr, len, size, burst, len, 1'b1, r, fw, pb);
            model_write(addr, len, burst);
            total++;
            if (r !== (exp_err(addr, len, size, burst) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL rand_bresp %0d: got %b want %b (addr=%h len=%0d burst=%b size=%b)",
                                n, r, exp_err(addr, len, size, burst) ? 2'b10 : 2'b00, addr, len, burst, size);
            end
            axi_read(addr, len, size, burst, n[0], fr);
            check_read("rand_read", addr, len, size, burst);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_incr_stall();
        test_partial();
        test_wrap();
        test_errors();
        test_reset_midburst();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
